uart_frame_deserializer: RTL and testbench

Parametrised UART receive-side frame deserializer, the successor to the fixed 8-bit deserializer. It consumes one already-sampled bit per bit period from the RX sampler and walks the frame through start, data, optional parity and stop fields with its own FSM and bit counter. It delivers a registered parallel word with a one-cycle valid pulse, plus parity-error and stop-error pulses. It sits between the RX data sampler and the RX output register / system controller.

---
 rtl/uart_frame_deserializer.sv | 174 +++++++++++++++++
 tb/tb_uart_frame_deserializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_deserializer.sv
// uart_frame_deserializer
// Receive-side UART frame deserializer. Consumes one pre-sampled bit per
// sample_valid strobe and walks start / data / [parity] / stop fields.
// Delivers P_DATA with a one-cycle data_valid pulse on a clean frame, or
// par_err / stp_err pulses on a bad one (P_DATA is then left untouched).
// Optional feature macro: DESER_PARITY_EN (adds the PARITY field/state).
module uart_frame_deserializer #(
    parameter int DATA_WIDTH = 8,   // 5..9
    parameter int MSB_FIRST  = 0,   // 1: first data bit lands in the MSB
    parameter int STOP_BITS  = 1    // 1..2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sample_valid,
    input  logic                  sampled_bit,
    input  logic                  par_typ,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int              IDXW      = $clog2(DATA_WIDTH + 1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DATA_WIDTH - 1);
    localparam logic [1:0]      LAST_STOP = 2'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2
`ifdef DESER_PARITY_EN
        ,
        PARITY = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         bit_idx_q;
    logic [1:0]              stop_idx_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    stop_fail_q;
    logic [DATA_WIDTH-1:0]   pdata_q;
    logic                    dv_q, se_q;
    logic                    frame_done, stop_bad, par_bad;
    logic                    dv_d, se_d;

`ifdef DESER_PARITY_EN
    logic                    acc_q, ptyp_q, par_fail_q, pe_q, pe_d;
`else
    logic                    unused_par_typ;
    assign unused_par_typ = par_typ;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort wins over a coincident strobe
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (sample_valid) begin
            case (state_q)
                IDLE: if (!sampled_bit) state_d = DATA;
`ifdef DESER_PARITY_EN
                DATA:   if (bit_idx_q == LAST_IDX) state_d = PARITY;
                PARITY: state_d = STOP;
`else
                DATA:   if (bit_idx_q == LAST_IDX) state_d = STOP;
`endif
                STOP: if (stop_idx_q == LAST_STOP) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Completion decode: the strobe carrying the last stop bit closes the frame
    always_comb begin
        frame_done = !abort && sample_valid && (state_q == STOP) &&
                     (stop_idx_q == LAST_STOP);
        stop_bad   = stop_fail_q | ~sampled_bit;
`ifdef DESER_PARITY_EN
        par_bad    = par_fail_q;
        pe_d       = frame_done & par_bad;
`else
        par_bad    = 1'b0;
`endif
        dv_d       = frame_done & ~stop_bad & ~par_bad;
        se_d       = frame_done & stop_bad;
    end

    // Datapath: shift register, counters, error flags and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_idx_q   <= '0;
            stop_idx_q  <= '0;
            shift_q     <= '0;
            stop_fail_q <= 1'b0;
            pdata_q     <= '0;
            dv_q        <= 1'b0;
            se_q        <= 1'b0;
`ifdef DESER_PARITY_EN
            acc_q       <= 1'b0;
            ptyp_q      <= 1'b0;
            par_fail_q  <= 1'b0;
            pe_q        <= 1'b0;
`endif
        end else begin
            dv_q <= dv_d;
            se_q <= se_d;
`ifdef DESER_PARITY_EN
            pe_q <= pe_d;
`endif
            if (dv_d) pdata_q <= shift_q;

            if (abort) begin
                bit_idx_q   <= '0;
                stop_idx_q  <= '0;
                stop_fail_q <= 1'b0;
`ifdef DESER_PARITY_EN
                acc_q       <= 1'b0;
                par_fail_q  <= 1'b0;
`endif
            end else if (sample_valid) begin
                case (state_q)
                    IDLE: if (!sampled_bit) begin
                        bit_idx_q   <= '0;
                        stop_idx_q  <= '0;
                        stop_fail_q <= 1'b0;
`ifdef DESER_PARITY_EN
                        acc_q       <= 1'b0;
                        ptyp_q      <= par_typ;
                        par_fail_q  <= 1'b0;
`endif
                    end
                    DATA: begin
                        if (MSB_FIRST != 0)
                            shift_q <= {shift_q[DATA_WIDTH-2:0], sampled_bit};
                        else
                            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        bit_idx_q <= bit_idx_q + IDXW'(1);
`ifdef DESER_PARITY_EN
                        acc_q     <= acc_q ^ sampled_bit;
`endif
                    end
`ifdef DESER_PARITY_EN
                    PARITY: par_fail_q <= sampled_bit ^ acc_q ^ ptyp_q;
`endif
                    STOP: begin
                        stop_fail_q <= stop_bad;
                        stop_idx_q  <= frame_done ? 2'd0 : stop_idx_q + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign stp_err    = se_q;
    assign busy       = (state_q != IDLE);
`ifdef DESER_PARITY_EN
    assign par_err    = pe_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_deserializer.sv
// Bench for uart_frame_deserializer: two instances (defaults, and
// MSB_FIRST=1/DATA_WIDTH=7/STOP_BITS=2) checked every cycle against a
// frame-level model, plus directed frames with hand-computed results.
module tb_uart_frame_deserializer;

`ifdef DESER_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] sv  = '0;
    logic [1:0] sb  = '1;
    logic       ptyp  = 1'b0;
    logic       abort = 1'b0;

    logic [7:0] pd0;
    logic [6:0] pd1;
    logic [1:0] dv, pe, se, bsy;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 CLK = ~CLK;

    uart_frame_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .STOP_BITS(1)) u0 (
        .CLK(CLK), .RST(RST), .sample_valid(sv[0]), .sampled_bit(sb[0]),
        .par_typ(ptyp), .abort(abort), .P_DATA(pd0), .data_valid(dv[0]),
        .par_err(pe[0]), .stp_err(se[0]), .busy(bsy[0]));

    uart_frame_deserializer #(.DATA_WIDTH(7), .MSB_FIRST(1), .STOP_BITS(2)) u1 (
        .CLK(CLK), .RST(RST), .sample_valid(sv[1]), .sampled_bit(sb[1]),
        .par_typ(ptyp), .abort(abort), .P_DATA(pd1), .data_valid(dv[1]),
        .par_err(pe[1]), .stp_err(se[1]), .busy(bsy[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int         dwv[2]  = '{8, 7};
    bit         msbv[2] = '{1'b0, 1'b1};
    int         sbv[2]  = '{1, 2};
    bit         infr[2];
    int         cnt[2];
    bit         ptl[2];
    logic [15:0] fb[2];
    logic [8:0] epd[2];
    bit         edv[2], epe[2], ese[2], ebsy[2];

    // Collect the bits of each frame after the start bit; judge it once complete
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            edv[k] = 0; epe[k] = 0; ese[k] = 0;
            if (RST) begin
                infr[k] = 0; cnt[k] = 0; epd[k] = '0;
            end else if (abort) begin
                infr[k] = 0; cnt[k] = 0;
            end else if (sv[k]) begin
                if (!infr[k]) begin
                    if (!sb[k]) begin infr[k] = 1; cnt[k] = 0; ptl[k] = ptyp; end
                end else begin
                    fb[k][cnt[k]] = sb[k];
                    cnt[k]++;
                    if (cnt[k] == dwv[k] + PEN + sbv[k]) begin
                        logic [8:0] w;
                        bit acc, perr, serr;
                        w = '0; acc = 0; perr = 0; serr = 0;
                        for (int i = 0; i < dwv[k]; i++) begin
                            if (msbv[k]) w[dwv[k]-1-i] = fb[k][i];
                            else         w[i]          = fb[k][i];
                            acc ^= fb[k][i];
                        end
                        if (PEN == 1) perr = (fb[k][dwv[k]] != (acc ^ ptl[k]));
                        for (int j = 0; j < sbv[k]; j++)
                            if (fb[k][dwv[k]+PEN+j] == 1'b0) serr = 1;
                        epe[k] = perr;
                        ese[k] = serr;
                        edv[k] = !perr && !serr;
                        if (edv[k]) epd[k] = w;
                        infr[k] = 0;
                    end
                end
            end
            ebsy[k] = infr[k];
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge CLK) begin
        if (started) begin
            chk("u0.P_DATA", {24'd0, pd0}, {23'd0, epd[0]});
            chk("u0.data_valid", {31'd0, dv[0]}, {31'd0, edv[0]});
            chk("u0.par_err", {31'd0, pe[0]}, {31'd0, epe[0]});
            chk("u0.stp_err", {31'd0, se[0]}, {31'd0, ese[0]});
            chk("u0.busy", {31'd0, bsy[0]}, {31'd0, ebsy[0]});
            chk("u1.P_DATA", {25'd0, pd1}, {23'd0, epd[1]});
            chk("u1.data_valid", {31'd0, dv[1]}, {31'd0, edv[1]});
            chk("u1.par_err", {31'd0, pe[1]}, {31'd0, epe[1]});
            chk("u1.stp_err", {31'd0, se[1]}, {31'd0, ese[1]});
            chk("u1.busy", {31'd0, bsy[1]}, {31'd0, ebsy[1]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input int k, input logic b);
        sv[k] = 1'b1; sb[k] = b;
        @(negedge CLK);
        sv[k] = 1'b0; sb[k] = 1'b1;
    endtask

    // Start bit, data in wire order, optional parity bit, stop bits
    task automatic frame(input int k, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
        strobe(k, 1'b0);
        for (int i = 0; i < dwv[k]; i++)
            strobe(k, msbv[k] ? d[dwv[k]-1-i] : d[i]);
        if (PEN == 1) strobe(k, pbit);
        for (int j = 0; j < sbv[k]; j++) strobe(k, stops[j]);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset.P_DATA", {24'd0, pd0}, 32'h0);
        chk("reset.busy", {30'd0, bsy}, 32'h0);
        chk("reset.pulses", {26'd0, dv, pe, se}, 32'h0);
        RST = 1'b0;
        started = 1'b1;
        @(negedge CLK);

        // 0xA5 LSB first, even parity bit 0, good stop
        ptyp = 1'b0;
        frame(0, 9'h0A5, 1'b0, 2'b11);
        chk("a5.P_DATA", {24'd0, pd0}, 32'hA5);
        chk("a5.data_valid", {31'd0, dv[0]}, 32'h1);
        chk("a5.busy", {31'd0, bsy[0]}, 32'h0);
        @(negedge CLK);
        chk("a5.pulse_width", {31'd0, dv[0]}, 32'h0);

`ifdef DESER_PARITY_EN
        // Odd parity expects 1, frame carries 0
        ptyp = 1'b1;
        frame(0, 9'h0A5, 1'b0, 2'b11);
        chk("odd.par_err", {31'd0, pe[0]}, 32'h1);
        chk("odd.data_valid", {31'd0, dv[0]}, 32'h0);
        chk("odd.P_DATA", {24'd0, pd0}, 32'hA5);
        ptyp = 1'b0;
        @(negedge CLK);
`endif

        // u1: MSB first 7 bits 1100001 -> 0x61
        frame(1, 9'h061, ^7'h61, 2'b11);
        chk("msb.P_DATA", {25'd0, pd1}, 32'h61);
        chk("msb.data_valid", {31'd0, dv[1]}, 32'h1);
        chk("msb.par_err", {31'd0, pe[1]}, 32'h0);

        // u1: stop bits 1 then 0 -> stp_err only after second stop strobe
        strobe(1, 1'b0);
        for (int i = 0; i < 7; i++) strobe(1, 1'b1);
        if (PEN == 1) strobe(1, 1'b1);
        strobe(1, 1'b1);
        chk("stop2.mid_busy", {31'd0, bsy[1]}, 32'h1);
        chk("stop2.mid_stp_err", {31'd0, se[1]}, 32'h0);
        strobe(1, 1'b0);
        chk("stop2.stp_err", {31'd0, se[1]}, 32'h1);
        chk("stop2.data_valid", {31'd0, dv[1]}, 32'h0);
        chk("stop2.P_DATA", {25'd0, pd1}, 32'h61);

        // Abort on the 4th data strobe, then a clean 0x3C frame
        strobe(0, 1'b0);
        strobe(0, 1'b0); strobe(0, 1'b0); strobe(0, 1'b1);
        abort = 1'b1;
        strobe(0, 1'b1);
        abort = 1'b0;
        chk("abort.busy", {31'd0, bsy[0]}, 32'h0);
        chk("abort.pulses", {29'd0, dv[0], pe[0], se[0]}, 32'h0);
        frame(0, 9'h03C, ^8'h3C, 2'b11);
        chk("post_abort.P_DATA", {24'd0, pd0}, 32'h3C);

        // Reset mid-DATA, then a leading idle 1 and a 0x5A frame
        strobe(0, 1'b0); strobe(0, 1'b1); strobe(0, 1'b0);
        #2 RST = 1'b1;
        #1;
        chk("rst.P_DATA", {24'd0, pd0}, 32'h0);
        chk("rst.busy", {30'd0, bsy}, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        strobe(0, 1'b1);
        chk("rst.idle_one", {31'd0, bsy[0]}, 32'h0);
        frame(0, 9'h05A, ^8'h5A, 2'b11);
        chk("rst.P_DATA_5A", {24'd0, pd0}, 32'h5A);
        chk("rst.data_valid", {31'd0, dv[0]}, 32'h1);

        // Randomized streams on both instances
        for (int c = 0; c < 4000; c++) begin
            sv[0] = ($urandom_range(0, 2) != 0);
            sv[1] = ($urandom_range(0, 3) == 0);
            sb[0] = ($urandom_range(0, 3) != 0);
            sb[1] = ($urandom_range(0, 3) != 0);
            ptyp  = $urandom_range(0, 1);
            abort = ($urandom_range(0, 150) == 0);
            @(negedge CLK);
        end
        sv = '0; abort = 1'b0;
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
